// File: rtl/xif_result_arb_if.sv
// Xif result channel: one coprocessor-to-core result transfer with valid/ready handshake.
// master drives the result payload, slave returns result_ready.
interface xif_result_arb_if;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        result_we;
    logic [5:0]  result_ecsdata;
    logic [2:0]  result_ecswe;
    logic        result_exc;
    logic [5:0]  result_exccode;
    logic        result_err;
    logic        result_dbg;

    modport master (
        output result_valid, result_id, result_data, result_rd, result_we,
               result_ecsdata, result_ecswe, result_exc, result_exccode,
               result_err, result_dbg,
        input  result_ready
    );

    modport slave (
        input  result_valid, result_id, result_data, result_rd, result_we,
               result_ecsdata, result_ecswe, result_exc, result_exccode,
               result_err, result_dbg,
        output result_ready
    );
endinterface

// File: rtl/xif_result_arb.sv
// xif_result_arb: round-robin merge of N_COPROC Xif result channels onto the core result port.
// Define XIF_RESULT_ARB_OUT_REG_EN to insert a 2-entry spill register on the core side.
module xif_result_arb #(
    parameter int unsigned N_COPROC = 3,
    parameter int unsigned IDX_W    = (N_COPROC > 1) ? $clog2(N_COPROC) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    xif_result_arb_if.slave  xif_result_if_i [N_COPROC],
    xif_result_arb_if.master xif_result_if_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_lock_o
);
    localparam int unsigned PL_W = 60;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;

    logic [N_COPROC-1:0] valid_in;
    logic [N_COPROC-1:0] ready_out;
    logic [PL_W-1:0]     pl_in [N_COPROC];

    logic                rr_found;
    logic [IDX_W-1:0]    rr_idx;
    int unsigned         cand;

    logic                own;
    logic [IDX_W-1:0]    own_idx;
    logic                arb_valid;
    logic                arb_ready;
    logic [PL_W-1:0]     arb_pl;

    logic                core_valid;
    logic                core_ready;
    logic [PL_W-1:0]     core_pl;

    // Flatten the interface array so ports can be selected by a runtime index.
    for (genvar g = 0; g < N_COPROC; g++) begin : g_port
        assign valid_in[g] = xif_result_if_i[g].result_valid;
        assign pl_in[g]    = {xif_result_if_i[g].result_id,      xif_result_if_i[g].result_data,
                              xif_result_if_i[g].result_rd,      xif_result_if_i[g].result_we,
                              xif_result_if_i[g].result_ecsdata, xif_result_if_i[g].result_ecswe,
                              xif_result_if_i[g].result_exc,     xif_result_if_i[g].result_exccode,
                              xif_result_if_i[g].result_err,     xif_result_if_i[g].result_dbg};
        assign xif_result_if_i[g].result_ready = ready_out[g];
    end

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] idx);
        if (32'(idx) >= N_COPROC - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    // First valid port at or after the pointer, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int unsigned o = 0; o < N_COPROC; o++) begin
            cand = 32'(ptr_q) + o;
            if (cand >= N_COPROC) begin
                cand = cand - N_COPROC;
            end
            if (!rr_found && valid_in[IDX_W'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Lock FSM: the owner is held from the first stalled cycle until its handshake.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        own        = 1'b0;
        own_idx    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    own     = 1'b1;
                    own_idx = rr_idx;
                    if (arb_ready) begin
                        ptr_d = inc_wrap(rr_idx);
                    end else begin
                        state_d    = S_LOCKED;
                        lock_idx_d = rr_idx;
                    end
                end
            end
            S_LOCKED: begin
                own     = 1'b1;
                own_idx = lock_idx_q;
                if (!valid_in[lock_idx_q]) begin
                    state_d = S_IDLE;
                end else if (arb_ready) begin
                    state_d = S_IDLE;
                    ptr_d   = inc_wrap(lock_idx_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst_i) begin
            own = 1'b0;
        end
    end

    assign arb_valid = own & valid_in[own_idx];
    assign arb_pl    = own ? pl_in[own_idx] : '0;

    always_comb begin
        ready_out = '0;
        if (own) begin
            ready_out[own_idx] = arb_ready;
        end
    end

    assign grant_idx_o  = own ? own_idx : '0;
    assign grant_lock_o = arb_valid & ~arb_ready;

`ifdef XIF_RESULT_ARB_OUT_REG_EN
    logic [PL_W-1:0] slot_q [2];
    logic [1:0]      cnt_q;
    logic            wr_q;
    logic            rd_q;
    logic            push;
    logic            pop;

    // Ready depends only on spill occupancy, never on the core's ready.
    assign arb_ready  = (cnt_q != 2'd2);
    assign push       = arb_valid & arb_ready;
    assign core_valid = (cnt_q != 2'd0);
    assign pop        = core_valid & core_ready;
    assign core_pl    = slot_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            cnt_q     <= 2'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            if (push) begin
                slot_q[wr_q] <= arb_pl;
                wr_q         <= ~wr_q;
            end
            if (pop) begin
                slot_q[rd_q] <= '0;
                rd_q         <= ~rd_q;
            end
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end
`else
    assign arb_ready  = core_ready;
    assign core_valid = arb_valid;
    assign core_pl    = arb_pl;
`endif

    assign core_ready                   = xif_result_if_o.result_ready;
    assign xif_result_if_o.result_valid = core_valid;
    assign {xif_result_if_o.result_id,      xif_result_if_o.result_data,
            xif_result_if_o.result_rd,      xif_result_if_o.result_we,
            xif_result_if_o.result_ecsdata, xif_result_if_o.result_ecswe,
            xif_result_if_o.result_exc,     xif_result_if_o.result_exccode,
            xif_result_if_o.result_err,     xif_result_if_o.result_dbg} = core_pl;

`ifndef SYNTHESIS
    // A locked owner must keep its result valid until the core accepts it.
    a_lock_owner_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == S_LOCKED) |-> valid_in[lock_idx_q]);
`endif

endmodule
